// File: rtl/fetch_pkg.sv
// Shared constants and the FIFO entry layout for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W = 7;
  localparam int PC_INC = 4;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc_inc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {instr, pc_inc} entries. Flush discards
// everything at once, so a redirect clears the wrong path in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];

  // Next pointers, count and storage; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues one-word memory reads,
// buffers returned words with PC+4 and hands them to decode.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 7,
  parameter int PC_START = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc_inc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_inc_q, inflight_pc_inc_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;

  logic              pop;
  logic              push;
  logic [CNT_W-1:0]  count;
  logic [OCC_W-1:0]  occupancy;
  fetch_entry_t      head;
  fetch_entry_t      push_data;

  // Handshake and request gating; occupancy counts the word in flight so
  // a request is only issued when its response is guaranteed a slot.
  always_comb begin
    if_valid         = (count != '0) & ~redirect;
    pop              = if_valid & if_ready;
    occupancy        = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
    imem_req         = ~reset & ~redirect & (occupancy < OCC_W'(DEPTH));
    imem_addr        = fetch_pc_q;
    push             = inflight_q & ~kill_q & ~redirect;
    push_data.instr  = imem_rdata;
    push_data.pc_inc = inflight_pc_inc_q;
    if_instr         = head.instr;
    if_pc_inc        = head.pc_inc;
  end

  // Next PC and in-flight tracking; a redirect realigns the PC to a word.
  always_comb begin
    fetch_pc_d        = fetch_pc_q;
    inflight_d        = imem_req;
    inflight_pc_inc_d = inflight_pc_inc_q;
    kill_d            = redirect;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~ADDR_W'(3);
    end else if (imem_req) begin
      fetch_pc_d        = fetch_pc_q + ADDR_W'(PC_INC);
      inflight_pc_inc_d = fetch_pc_q + ADDR_W'(PC_INC);
    end
  end

  // PC and in-flight registers; reset drops any outstanding response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q        <= ADDR_W'(PC_START);
      inflight_pc_inc_q <= '0;
      inflight_q        <= 1'b0;
      kill_q            <= 1'b0;
    end else begin
      fetch_pc_q        <= fetch_pc_d;
      inflight_pc_inc_q <= inflight_pc_inc_d;
      inflight_q        <= inflight_d;
      kill_q            <= kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect),
    .count    (count),
    .head     (head)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a one-cycle-latency memory model.
module tb_instr_fetch_queue;

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [6:0]  exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [6:0]  exp_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect = 1'b0;
  logic [6:0]  redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [6:0]  if_pc_inc;

  int checkCount = 0;
  int failCount  = 0;

  vec_t vecs [16];

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .DEPTH   (4),
    .ADDR_W  (7),
    .PC_START(0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc_inc  (if_pc_inc)
  );

  // Word stored at a byte address: 0x11111111 * (n+1) for the first words,
  // then a distinct tagged value so every word in memory is unique.
  function automatic logic [31:0] memWord(input logic [6:0] addr);
    logic [4:0] idx;
    idx = addr[6:2];
    if (idx < 5'd15) return 32'h1111_1111 * (32'(idx) + 32'd1);
    return 32'hA000_0000 | 32'(idx);
  endfunction

  // Instruction memory: the word is presented one cycle after the request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= memWord(imem_addr);
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic redir, input logic [6:0] rpc);
    @(negedge clk);
    reset       = 1'b0;
    if_ready    = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic checkCycle(input string tag, input logic expReq, input logic [6:0] expAddr,
                            input logic expValid, input logic [31:0] expInstr,
                            input logic [6:0] expPc);
    checkOutput({tag, ".req"}, 32'(imem_req), 32'(expReq));
    if (expReq) checkOutput({tag, ".addr"}, 32'(imem_addr), 32'(expAddr));
    checkOutput({tag, ".valid"}, 32'(if_valid), 32'(expValid));
    if (expValid) begin
      checkOutput({tag, ".instr"}, if_instr, expInstr);
      checkOutput({tag, ".pc_inc"}, 32'(if_pc_inc), 32'(expPc));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".req"}, 32'(imem_req), 32'd0);
    checkOutput({tag, ".valid"}, 32'(if_valid), 32'd0);
    checkOutput({tag, ".instr"}, if_instr, 32'd0);
    checkOutput({tag, ".pc_inc"}, 32'(if_pc_inc), 32'd0);
  endtask

  task automatic doReset();
    reset    = 1'b1;
    redirect = 1'b0;
    if_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs("reset");
  endtask

  initial begin
    // Stall from reset, then drain with if_ready high.
    vecs[0]  = '{1'b0, 1'b1, 7'h00, 1'b0, 32'h0, 7'h00};
    vecs[1]  = '{1'b0, 1'b1, 7'h04, 1'b0, 32'h0, 7'h00};
    vecs[2]  = '{1'b0, 1'b1, 7'h08, 1'b1, 32'h1111_1111, 7'h04};
    vecs[3]  = '{1'b0, 1'b1, 7'h0C, 1'b1, 32'h1111_1111, 7'h04};
    vecs[4]  = '{1'b0, 1'b0, 7'h10, 1'b1, 32'h1111_1111, 7'h04};
    vecs[5]  = '{1'b0, 1'b0, 7'h10, 1'b1, 32'h1111_1111, 7'h04};
    vecs[6]  = '{1'b0, 1'b0, 7'h10, 1'b1, 32'h1111_1111, 7'h04};
    vecs[7]  = '{1'b0, 1'b0, 7'h10, 1'b1, 32'h1111_1111, 7'h04};
    vecs[8]  = '{1'b0, 1'b0, 7'h10, 1'b1, 32'h1111_1111, 7'h04};
    vecs[9]  = '{1'b0, 1'b0, 7'h10, 1'b1, 32'h1111_1111, 7'h04};
    vecs[10] = '{1'b1, 1'b1, 7'h10, 1'b1, 32'h1111_1111, 7'h04};
    vecs[11] = '{1'b1, 1'b1, 7'h14, 1'b1, 32'h2222_2222, 7'h08};
    vecs[12] = '{1'b1, 1'b1, 7'h18, 1'b1, 32'h3333_3333, 7'h0C};
    vecs[13] = '{1'b1, 1'b1, 7'h1C, 1'b1, 32'h4444_4444, 7'h10};
    vecs[14] = '{1'b1, 1'b1, 7'h20, 1'b1, 32'h5555_5555, 7'h14};
    vecs[15] = '{1'b1, 1'b1, 7'h24, 1'b1, 32'h6666_6666, 7'h18};

    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rdy, 1'b0, 7'h00);
      checkCycle($sformatf("stream.c%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                 vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_pc);
    end

    // Redirect to 0x40 with three entries queued and one response in flight.
    doReset();
    repeat (4) applyStimulus(1'b0, 1'b0, 7'h00);
    applyStimulus(1'b0, 1'b1, 7'h40);
    checkCycle("redir40.R", 1'b0, 7'h00, 1'b0, 32'h0, 7'h00);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("redir40.R1", 1'b1, 7'h40, 1'b0, 32'h0, 7'h00);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("redir40.R2", 1'b1, 7'h44, 1'b0, 32'h0, 7'h00);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("redir40.R3", 1'b1, 7'h48, 1'b1, 32'hA000_0010, 7'h44);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("redir40.R4", 1'b1, 7'h4C, 1'b1, 32'hA000_0011, 7'h48);

    // Redirect while full with if_ready high; unaligned target 0x13.
    doReset();
    repeat (5) applyStimulus(1'b0, 1'b0, 7'h00);
    applyStimulus(1'b0, 1'b0, 7'h00);
    checkCycle("full.pre", 1'b0, 7'h10, 1'b1, 32'h1111_1111, 7'h04);
    applyStimulus(1'b1, 1'b1, 7'h13);
    checkCycle("full.R", 1'b0, 7'h00, 1'b0, 32'h0, 7'h00);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("full.R1", 1'b1, 7'h10, 1'b0, 32'h0, 7'h00);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("full.R2", 1'b1, 7'h14, 1'b0, 32'h0, 7'h00);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("full.R3", 1'b1, 7'h18, 1'b1, 32'h5555_5555, 7'h14);

    // Sequential fetch across the top of the address space.
    applyStimulus(1'b1, 1'b1, 7'h78);
    checkCycle("wrap.R", 1'b0, 7'h00, 1'b0, 32'h0, 7'h00);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("wrap.R1", 1'b1, 7'h78, 1'b0, 32'h0, 7'h00);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("wrap.R2", 1'b1, 7'h7C, 1'b0, 32'h0, 7'h00);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("wrap.R3", 1'b1, 7'h00, 1'b1, 32'hA000_001E, 7'h7C);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("wrap.R4", 1'b1, 7'h04, 1'b1, 32'hA000_001F, 7'h00);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("wrap.R5", 1'b1, 7'h08, 1'b1, 32'h1111_1111, 7'h04);

    // Asynchronous reset mid-flight: outputs clear at once, response dropped.
    #2;
    reset = 1'b1;
    #1;
    checkResetOutputs("asyncrst");
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("rst.c0", 1'b1, 7'h00, 1'b0, 32'h0, 7'h00);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("rst.c1", 1'b1, 7'h04, 1'b0, 32'h0, 7'h00);
    applyStimulus(1'b1, 1'b0, 7'h00);
    checkCycle("rst.c2", 1'b1, 7'h08, 1'b1, 32'h1111_1111, 7'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
